ahb_axi4l_bridge_p: RTL and testbench
=====================================

# ahb_axi4l_bridge_p

Parametrised AHB-Lite slave to AXI4-Lite master bridge, one outstanding transfer at a time. It sits between the processor AHB-Lite fabric and the AXI4-Lite register and peripheral interconnect of the recognition pipeline. It supports:
- independent AW/W handshakes;
- B/R response mapping to the AHB two-cycle ERROR response;
- byte-lane strobe generation for any legal HSIZE;
- an optional response watchdog.

## Interface
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width on both sides; legal values are 32 and 64.
- TIMEOUT_CYC, 256, watchdog limit in clk cycles; only used with the watchdog macro.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- hsel, hready_in, hwrite  in  1  AHB select, fabric HREADY, direction.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type.
- hsize  in  3  AHB transfer size.
- hprot  in  4  AHB protection.
- hwdata  in  DATA_W  AHB write data.
- hrdata  out  DATA_W  AHB read data.
- hreadyout  out  1  AHB slave ready.
- hresp  out  1  AHB response: 0 = OKAY, 1 = ERROR.
- awaddr/araddr  out  ADDR_W  AXI write and read addresses.
- awprot/arprot  out  3  AXI protection.
- awvalid, arvalid, wvalid, bready, rready  out  1  AXI handshake outputs.
- awready, arready, wready, bvalid, rvalid  in  1  AXI handshake inputs.
- wdata  out  DATA_W  AXI write data.
- wstrb  out  DATA_W/8  AXI write strobes.
- bresp, rresp  in  2  AXI responses.
- rdata  in  DATA_W  AXI read data.

## Operation
- **Reset values:** hreadyout=1, hresp=0, hrdata=0, all AXI valid and ready outputs 0, addresses/wdata/wstrb 0, FSM=IDLE.
- **Transfer acceptance:** a transfer is accepted when hsel & htrans[1] & hready_in & hreadyout. Sampling occurs in IDLE and ERR2 only.
- **Captured fields:** haddr, hwrite, hsize.
- **Protection mapping:** prot = {~hprot[0], 1'b0, hprot[1]}.
- **Size checks:** if hsize > log2(DATA_W/8), or haddr is not aligned to hsize, go to ERR1 with no AXI activity.
- **FSM states:** IDLE, WCAP, WREQ, WRESP, RREQ, RRESP, ERR1, ERR2.
- **IDLE:**
  - Write accepted -> WCAP.
  - Read accepted -> RREQ.
  - htrans IDLE or BUSY -> stay in IDLE, OKAY zero-wait.
- **WCAP:** hreadyout=0. Latch hwdata into wdata. Latch wstrb = ((1<<(1<<hsize))-1) << haddr[log2(DATA_W/8)-1:0]. Go to WREQ.
- **WREQ:**
  - awvalid and wvalid are asserted together.
  - Each valid deasserts independently on its own ready.
  - Once both handshakes are done -> WRESP.
- **WRESP:** bready=1. On bvalid: bresp[1]=0 -> IDLE with hreadyout=1, hresp=0; otherwise -> ERR1.
- **RREQ:** arvalid=1 until arready -> RRESP.
- **RRESP:** rready=1. On rvalid, rdata is registered into hrdata. Then rresp[1]=0 -> IDLE (OKAY), else ERR1. hrdata holds until the next read completes.
- **ERR1:** hreadyout=0, hresp=1.
- **ERR2:** hreadyout=1, hresp=1. A new address phase is sampled here, then the FSM behaves as IDLE.
- **Response codes:** EXOKAY (01) maps to OKAY. SLVERR and DECERR map to ERROR.
- **Stray responses:** bvalid/rvalid in any state other than WRESP/RRESP are ignored (ready held 0).
- **Reset mid-transfer:** everything returns to reset values immediately; the in-flight AXI transaction is abandoned.

## Timing
- hreadyout is low from the first data-phase cycle until the completion cycle.
- **Write, zero-wait AXI:** address phase at cycle 0, WCAP at 1, WREQ at 2 (awready=wready=1), WRESP at 3 (bvalid=1), completion (hreadyout=1) at 4.
- **Read, zero-wait AXI:** RREQ at 1, RRESP at 2, completion at 3 with hrdata valid.
- **AXI stalls:** each AXI wait cycle adds one cycle.
- **Error path:** adds two cycles (ERR1, ERR2) after the failing response.
- **Back-to-back:** a new transfer accepted in the completion cycle starts with no bubble.
- **Handshake rule:** once a valid is asserted, it and its payload stay stable until ready, with no combinational path from ready to valid.

## Configuration
- AHB_AXI_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on entry to WREQ/RREQ.
  - It counts every cycle spent in WREQ, WRESP, RREQ or RRESP.
  - At TIMEOUT_CYC, all AXI valids drop and the FSM goes to ERR1.
  - bready and rready are then held at 1 in IDLE, so late responses are drained and discarded.
- Undefined: there is no counter and the bridge waits indefinitely; bready and rready stay 0 outside WRESP/RRESP.

## Test plan
- 32-bit write, haddr=0x1000_0004, hsize=2, hwdata=0xA5A5_1234, all readys tied high -> awaddr=0x1000_0004, wstrb=0xF, wdata=0xA5A5_1234; hreadyout high at cycle 4, hresp=0.
- Byte write to haddr=0x...3 with hsize=0 -> wstrb=0x8. With awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle, awvalid is held 4 cycles, completion at cycle 7.
- Read with rdata=0xDEAD_BEEF, rresp=2 -> hresp=1 for two cycles (hreadyout 0 then 1) and hrdata=0xDEAD_BEEF.
- hsize=3 with DATA_W=32, or hsize=2 with haddr=0x2 -> ERR1/ERR2, and awvalid and arvalid never assert.
- Back-to-back read then write with NONSEQ presented in the completion cycle -> arvalid, then awvalid, with no idle cycle between the AHB data phases.
- With the macro defined and TIMEOUT_CYC=16, a read with arready held at 0 -> arvalid drops after 16 cycles, then ERROR response. A later stray rvalid is absorbed and the FSM stays in IDLE.

Source files
------------

// File: rtl/ahb_axi4l_bridge_p.sv
// AHB-Lite slave to AXI4-Lite master bridge, single outstanding transfer.
// Optional response watchdog enabled by defining AHB_AXI_BRIDGE_TIMEOUT_EN.
module ahb_axi4l_bridge_p #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsel,
    input  logic                  hready_in,
    input  logic                  hwrite,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [3:0]            hprot,
    input  logic [DATA_W-1:0]     hwdata,
    output logic [DATA_W-1:0]     hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam int         LANE_W   = (DATA_W == 64) ? 3 : 2;
    localparam logic [2:0] MAX_SIZE = 3'(LANE_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WCAP  = 3'd1,
        WREQ  = 3'd2,
        WRESP = 3'd3,
        RREQ  = 3'd4,
        RRESP = 3'd5,
        ERR1  = 3'd6,
        ERR2  = 3'd7
    } state_t;

    // Contiguous byte-lane mask for a transfer of 2**size bytes starting at lane.
    function automatic logic [STRB_W-1:0] strb_gen(input logic [2:0] size,
                                                   input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] m;
        int                nbytes;
        nbytes = int'(32'd1 << size);
        for (int i = 0; i < STRB_W; i++) begin
            m[i] = (i < nbytes) ? 1'b1 : 1'b0;
        end
        return STRB_W'(m << lane);
    endfunction

    // Oversized transfer or address not aligned to the transfer size.
    function automatic logic size_bad(input logic [2:0] size,
                                      input logic [LANE_W-1:0] lane);
        logic bad;
        bad = (size > MAX_SIZE) ? 1'b1 : 1'b0;
        for (int i = 0; i < LANE_W; i++) begin
            if ((i < int'(size)) && lane[i]) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    state_t              state_r;
    logic [2:0]          size_r;
    logic [LANE_W-1:0]   lane_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic [DATA_W-1:0]   hrdata_r;
    logic                hreadyout_r;
    logic                hresp_r;
    logic [ADDR_W-1:0]   awaddr_r;
    logic [ADDR_W-1:0]   araddr_r;
    logic [2:0]          awprot_r;
    logic [2:0]          arprot_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                arvalid_r;
    logic                bready_r;
    logic                rready_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;

    logic                accept_s;
    logic                size_err_s;
    logic [2:0]          prot_s;
    logic                aw_ok_s;
    logic                w_ok_s;
    logic                timeout_s;
    logic                drain_s;

    assign accept_s   = hsel & htrans[1] & hready_in & hreadyout_r &
                        ((state_r == IDLE) | (state_r == ERR2));
    assign size_err_s = size_bad(hsize, haddr[LANE_W-1:0]);
    assign prot_s     = {~hprot[0], 1'b0, hprot[1]};
    assign aw_ok_s    = (awvalid_r & awready) | aw_done_r;
    assign w_ok_s     = (wvalid_r & wready) | w_done_r;

`ifdef AHB_AXI_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             drain_r;
    logic             busy_s;
    logic             enter_s;
    logic             unused_s;

    assign busy_s    = (state_r == WREQ) | (state_r == WRESP) |
                       (state_r == RREQ) | (state_r == RRESP);
    assign enter_s   = (state_r == WCAP) | (accept_s & ~size_err_s & ~hwrite);
    assign timeout_s = busy_s & (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign drain_s   = drain_r;
    assign unused_s  = ^hprot[3:2];

    // Watchdog: restart on entry to a request state, count while waiting on AXI.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (enter_s) begin
            cnt_r <= '0;
        end else if (busy_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // After a timeout, keep ready high when idle so late responses are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_r <= 1'b0;
        end else if (timeout_s) begin
            drain_r <= 1'b1;
        end else begin
            drain_r <= drain_r;
        end
    end
`else
    logic unused_s;

    assign timeout_s = 1'b0;
    assign drain_s   = 1'b0;
    assign unused_s  = ^{hprot[3:2], (TIMEOUT_CYC > 0)};
`endif

    // Bridge FSM with all AHB and AXI outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            size_r      <= 3'd0;
            lane_r      <= '0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            hrdata_r    <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            awaddr_r    <= '0;
            araddr_r    <= '0;
            awprot_r    <= 3'd0;
            arprot_r    <= 3'd0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
        end else if (timeout_s) begin
            // Abandon the AXI transaction; drain readies stay up afterwards.
            state_r   <= ERR1;
            hresp_r   <= 1'b1;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            arvalid_r <= 1'b0;
            bready_r  <= 1'b1;
            rready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE, ERR2: begin
                    bready_r <= drain_s;
                    rready_r <= drain_s;
                    if (accept_s) begin
                        hreadyout_r <= 1'b0;
                        if (size_err_s) begin
                            state_r <= ERR1;
                            hresp_r <= 1'b1;
                        end else if (hwrite) begin
                            state_r  <= WCAP;
                            hresp_r  <= 1'b0;
                            awaddr_r <= haddr;
                            awprot_r <= prot_s;
                            size_r   <= hsize;
                            lane_r   <= haddr[LANE_W-1:0];
                        end else begin
                            state_r   <= RREQ;
                            hresp_r   <= 1'b0;
                            araddr_r  <= haddr;
                            arprot_r  <= prot_s;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        state_r     <= IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                    end
                end
                WCAP: begin
                    wdata_r   <= hwdata;
                    wstrb_r   <= strb_gen(size_r, lane_r);
                    awvalid_r <= 1'b1;
                    wvalid_r  <= 1'b1;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    rready_r  <= 1'b0;
                    state_r   <= WREQ;
                end
                WREQ: begin
                    if (awvalid_r & awready) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end else begin
                        aw_done_r <= aw_done_r;
                    end
                    if (wvalid_r & wready) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end else begin
                        w_done_r <= w_done_r;
                    end
                    if (aw_ok_s & w_ok_s) begin
                        state_r  <= WRESP;
                        bready_r <= 1'b1;
                    end else begin
                        state_r <= WREQ;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready_r <= drain_s;
                        if (bresp[1]) begin
                            state_r <= ERR1;
                            hresp_r <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= 1'b0;
                        end
                    end else begin
                        state_r <= WRESP;
                    end
                end
                RREQ: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RRESP;
                    end else begin
                        state_r <= RREQ;
                    end
                end
                RRESP: begin
                    if (rvalid) begin
                        hrdata_r <= rdata;
                        rready_r <= drain_s;
                        if (rresp[1]) begin
                            state_r <= ERR1;
                            hresp_r <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= 1'b0;
                        end
                    end else begin
                        state_r <= RRESP;
                    end
                end
                ERR1: begin
                    state_r     <= ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                end
            endcase
        end
    end

    assign hrdata    = hrdata_r;
    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign awaddr    = awaddr_r;
    assign awprot    = awprot_r;
    assign awvalid   = awvalid_r;
    assign wdata     = wdata_r;
    assign wstrb     = wstrb_r;
    assign wvalid    = wvalid_r;
    assign bready    = bready_r;
    assign araddr    = araddr_r;
    assign arprot    = arprot_r;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;

endmodule

// File: tb/tb_ahb_axi4l_bridge_p.sv
// Directed self-checking bench for ahb_axi4l_bridge_p (DATA_W=32).
module tb_ahb_axi4l_bridge_p;

`ifdef AHB_AXI_BRIDGE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic        clk;
    logic        reset;
    logic        hsel, hready_in, hwrite;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout, hresp;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, arvalid, wvalid, bready, rready;
    logic        awready, arready, wready, bvalid, rvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_err    = 0;

    ahb_axi4l_bridge_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .hsel(hsel), .hready_in(hready_in), .hwrite(hwrite), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] pr);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hprot  = pr;
    endtask

    task automatic addr_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        reset = 1'b0; hsel = 1'b0; hready_in = 1'b1; hwrite = 1'b0;
        haddr = 32'd0; htrans = 2'b00; hsize = 3'd0; hprot = 4'd0; hwdata = 32'd0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = 32'd0;
        step(); step();
        chk("rst_hreadyout", 64'(hreadyout), 64'd1);
        chk("rst_hresp",     64'(hresp),     64'd0);
        chk("rst_hrdata",    64'(hrdata),    64'd0);
        chk("rst_valids",    64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("rst_wstrb",     64'(wstrb),     64'd0);
        chk("rst_awaddr",    64'(awaddr),    64'd0);
        reset = 1'b1;
        step();

        // Word write, zero-wait AXI, EXOKAY response.
        bvalid = 1'b1; bresp = 2'b01;
        addr_phase(1'b1, 32'h1000_0004, 3'd2, 4'b0011);
        step();                                   // cycle 1: WCAP
        addr_idle(); hwdata = 32'hA5A5_1234;
        chk("w1_c1_hready", 64'(hreadyout), 64'd0);
        step();                                   // cycle 2: WREQ
        hwdata = 32'd0;
        chk("w1_c2_valids", 64'({awvalid, wvalid}), 64'b11);
        chk("w1_awaddr",    64'(awaddr), 64'h1000_0004);
        chk("w1_wstrb",     64'(wstrb),  64'hF);
        chk("w1_wdata",     64'(wdata),  64'hA5A5_1234);
        chk("w1_awprot",    64'(awprot), 64'b001);
        step();                                   // cycle 3: WRESP
        chk("w1_c3_valids", 64'({awvalid, wvalid, bready, hreadyout}), 64'b0010);
        step();                                   // cycle 4: completion
        chk("w1_c4_done",   64'({hreadyout, hresp, bready}), 64'b100);

        // Byte write at lane 3, awready late by three cycles.
        bresp = 2'b00; awready = 1'b0;
        addr_phase(1'b1, 32'h2000_0003, 3'd0, 4'b0011);
        step();                                   // cycle 1
        addr_idle(); hwdata = 32'h7700_0000;
        step();                                   // cycle 2
        chk("w2_c2_valids", 64'({awvalid, wvalid}), 64'b11);
        chk("w2_wstrb",     64'(wstrb), 64'h8);
        step();                                   // cycle 3
        chk("w2_c3_valids", 64'({awvalid, wvalid}), 64'b10);
        step();                                   // cycle 4
        chk("w2_c4_valids", 64'({awvalid, wvalid}), 64'b10);
        step();                                   // cycle 5
        awready = 1'b1;
        chk("w2_c5_valids", 64'({awvalid, wvalid, hreadyout}), 64'b100);
        step();                                   // cycle 6: WRESP
        chk("w2_c6",        64'({awvalid, bready, hreadyout}), 64'b010);
        step();                                   // cycle 7: completion
        chk("w2_c7_done",   64'({hreadyout, hresp}), 64'b10);
        bvalid = 1'b0;

        // Read with SLVERR: two-cycle ERROR, data still captured.
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        addr_phase(1'b0, 32'h3000_0008, 3'd2, 4'b0000);
        step();                                   // cycle 1: RREQ
        addr_idle();
        chk("r1_c1",        64'({arvalid, rready, hreadyout}), 64'b100);
        chk("r1_araddr",    64'(araddr), 64'h3000_0008);
        chk("r1_arprot",    64'(arprot), 64'b100);
        step();                                   // cycle 2: RRESP
        chk("r1_c2",        64'({arvalid, rready}), 64'b01);
        step();                                   // cycle 3: ERR1
        rvalid = 1'b0;
        chk("r1_err1",      64'({hreadyout, hresp}), 64'b01);
        chk("r1_hrdata",    64'(hrdata), 64'hDEAD_BEEF);
        step();                                   // cycle 4: ERR2
        chk("r1_err2",      64'({hreadyout, hresp}), 64'b11);
        step();
        chk("r1_idle",      64'({hreadyout, hresp}), 64'b10);

        // Oversized write: no AXI activity, ERROR response.
        addr_phase(1'b1, 32'h0000_0000, 3'd3, 4'b0000);
        step();
        addr_idle();
        chk("e1_err1",      64'({hreadyout, hresp, awvalid, wvalid, arvalid}), 64'b01000);
        step();
        chk("e1_err2",      64'({hreadyout, hresp, awvalid, arvalid}), 64'b1100);
        step();
        // Misaligned word read.
        addr_phase(1'b0, 32'h0000_0002, 3'd2, 4'b0000);
        step();
        addr_idle();
        chk("e2_err1",      64'({hreadyout, hresp, arvalid}), 64'b010);
        step();
        chk("e2_err2",      64'({hreadyout, hresp, arvalid, awvalid}), 64'b1100);
        step();

        // Back-to-back: read, then halfword write accepted in the completion cycle.
        rvalid = 1'b1; rresp = 2'b00; rdata = 32'h1234_5678; bvalid = 1'b1;
        addr_phase(1'b0, 32'h4000_0000, 3'd2, 4'b0000);
        step();                                   // cycle 1: RREQ
        addr_idle();
        chk("b2b_arvalid",  64'(arvalid), 64'd1);
        step();                                   // cycle 2: RRESP
        step();                                   // cycle 3: completion
        rvalid = 1'b0;
        chk("b2b_rdone",    64'({hreadyout, hresp}), 64'b10);
        chk("b2b_hrdata",   64'(hrdata), 64'h1234_5678);
        addr_phase(1'b1, 32'h4000_0012, 3'd1, 4'b0011);
        step();                                   // cycle 4: WCAP
        addr_idle(); hwdata = 32'hCAFE_0000;
        chk("b2b_wcap",     64'({hreadyout, arvalid}), 64'b00);
        step();                                   // cycle 5: WREQ
        chk("b2b_awvalid",  64'(awvalid), 64'd1);
        chk("b2b_awaddr",   64'(awaddr), 64'h4000_0012);
        chk("b2b_wstrb",    64'(wstrb), 64'hC);
        chk("b2b_wdata",    64'(wdata), 64'hCAFE_0000);
        step();                                   // cycle 6: WRESP
        step();                                   // cycle 7: completion
        bvalid = 1'b0;
        chk("b2b_wdone",    64'({hreadyout, hresp}), 64'b10);
        chk("b2b_hold",     64'(hrdata), 64'h1234_5678);

`ifdef AHB_AXI_BRIDGE_TIMEOUT_EN
        // Watchdog: arready never comes.
        arready = 1'b0;
        addr_phase(1'b0, 32'h5000_0000, 3'd2, 4'b0000);
        step();
        addr_idle();
        for (int c = 1; c < 16; c++) step();      // cycle 16
        chk("to_c16",       64'({arvalid, hreadyout}), 64'b10);
        step();                                   // cycle 17: ERR1
        chk("to_err1",      64'({arvalid, hreadyout, hresp}), 64'b001);
        step();
        chk("to_err2",      64'({hreadyout, hresp}), 64'b11);
        step();
        chk("to_drain",     64'({rready, bready}), 64'b11);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        step();
        rvalid = 1'b0;
        step();
        chk("to_stray",     64'({hreadyout, hresp, arvalid}), 64'b100);
        chk("to_hrdata",    64'(hrdata), 64'h1234_5678);
        arready = 1'b1;
`else
        // Stray responses outside WRESP/RRESP are ignored.
        bvalid = 1'b1; rvalid = 1'b1;
        step();
        chk("stray_ready",  64'({bready, rready, hreadyout, hresp}), 64'b0010);
        bvalid = 1'b0; rvalid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
